pma_tx_serializer: RTL and testbench
====================================

PMA_TX_SERIALIZER -- requirements
Module: pma_tx_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of 10-bit words buffered (power of two, 2..16).
REQ-002 SHALL have parameter IDLE_WORD, default 10'b0101010101, giving the word sent when no data is available (LSB first, so a 1,0,1,0 transition pattern for the far-end CDR).
REQ-003 SHALL have port clk, input, 1 bit: single clock at the serial bit rate (5 GHz, 0.2 ns period); one bit is sent per rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Data_In, input, 10 bits: 8b/10b-encoded parallel word.
REQ-006 SHALL have port Data_Valid, input, 1 bit: Data_In is valid.
REQ-007 SHALL have port Data_Ready, output, 1 bit: a word can be accepted.
REQ-008 SHALL have port Serial_Out, output, 1 bit: serial line bit, sent LSB first.
REQ-009 SHALL have port Word_Boundary, output, 1 bit: high while Serial_Out carries bit 0 of a word.
REQ-010 SHALL have port Underflow, output, 1 bit: one-cycle pulse when an idle word is inserted straight after a data word.

Function
REQ-011 SHALL accept a word on a rising edge where Data_Valid && Data_Ready are both high, and write it to the FIFO tail.
REQ-012 SHALL drive Data_Ready combinationally as (FIFO not full); a Data_Valid while Data_Ready is low SHALL be ignored and SHALL NOT be stored.
REQ-013 SHALL hold a 4-bit bit counter, bit_cnt (0..9), and a 10-bit shift register, sr; Serial_Out = sr[0] and Word_Boundary = (bit_cnt == 0), both combinational from registers.
REQ-014 On each rising edge with bit_cnt != 9, SHALL shift sr right by one and increment bit_cnt.
REQ-015 On each rising edge with bit_cnt == 9, SHALL set bit_cnt to 0 and load sr with the FIFO head (and pop it) if the FIFO is non-empty, otherwise with IDLE_WORD.
REQ-016 The empty test at a load SHALL use the FIFO state before that edge; a word pushed on the same edge SHALL NOT be sent until the next load.
REQ-017 A push and a pop on the same edge SHALL leave the occupancy unchanged; a pop when full SHALL raise Data_Ready in the following cycle.
REQ-018 Underflow SHALL go high for the cycle after a load edge that inserts IDLE_WORD when the word just finished was a data word; it SHALL stay low during continuous idle.
REQ-019 Latency: with the FIFO empty and the shifter idle, a word accepted on edge t SHALL start (Word_Boundary high) at the first load edge after t, which is at most 10 cycles later.
REQ-020 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH and use one extra bit to tell full from empty.

Reset
REQ-021 While rst_n is low, SHALL asynchronously clear the FIFO pointers and bit_cnt, set sr to IDLE_WORD, and clear the "last word was data" flag and Underflow.
REQ-022 Reset values: Serial_Out = IDLE_WORD[0], Word_Boundary = 1, Data_Ready = 1, Underflow = 0.
REQ-023 Asserting reset in the middle of a word SHALL discard the partial word and all buffered words; no residue SHALL be sent after release.

Configuration
REQ-024 When macro TX_PRBS_EN is defined, SHALL add input port Prbs_En (1 bit) and a PRBS7 LFSR (x^7+x^6+1, reset seed 7'h7F).
REQ-025 With TX_PRBS_EN defined and Prbs_En high: at each load, sr SHALL take the next 10 LFSR bits (the first bit generated goes in sr[0]), the FIFO SHALL NOT be popped, Data_Ready SHALL be 0, and Underflow SHALL be 0.
REQ-026 Without TX_PRBS_EN: no Prbs_En port and no LFSR SHALL exist, and behaviour SHALL be exactly REQ-011..REQ-023.

Verification
REQ-027 Reset release, no data for 30 cycles -> Serial_Out = 1,0,1,0,...; Word_Boundary high every 10th cycle; Underflow stays 0.
REQ-028 Push 10'h3A5 alone -> at the next load, Serial_Out = 1,0,1,0,0,1,0,1,1,1; then IDLE_WORD; Underflow pulses once.
REQ-029 Hold Data_Valid high with 5 words (FIFO_DEPTH = 4) -> Data_Ready falls after 4 accepts; words come out back-to-back in order with no idle between them; none lost.
REQ-030 Push on the same edge as a load with the FIFO empty -> IDLE_WORD is sent first; the pushed word starts exactly 10 cycles later.
REQ-031 Assert rst_n low at bit_cnt = 4 with 2 words buffered -> after release, only the idle pattern is sent and Data_Ready = 1.
REQ-032 (TX_PRBS_EN) Prbs_En = 1 after reset -> first 10 bits match a PRBS7 reference model with seed 7'h7F; sequence repeats every 127 bits; Data_Ready = 0.

Source files
------------

// File: rtl/pma_tx_serializer.sv
// PMA TX serializer: 10-bit word FIFO feeding an LSB-first shifter, idle-word fill on underrun.
// Build option TX_PRBS_EN adds the Prbs_En input and a PRBS7 source that replaces FIFO data.
`timescale 1ns/1ps

module pma_tx_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [9:0]  IDLE_WORD  = 10'b0101010101
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef TX_PRBS_EN
  input  logic       Prbs_En,
`endif
  input  logic [9:0] Data_In,
  input  logic       Data_Valid,
  output logic       Data_Ready,
  output logic       Serial_Out,
  output logic       Word_Boundary,
  output logic       Underflow
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW     = AW + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_sr;
  logic              r_last_data;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_load;
  logic              w_push;
  logic              w_pop;
  logic              w_prbs_on;
  logic [WORD_W-1:0] w_head;
  logic [WORD_W-1:0] w_load_word;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_load        = (r_bit_cnt == LAST_BIT);
  assign w_push        = Data_Valid && Data_Ready;
  assign w_pop         = w_load && !w_empty && !w_prbs_on;
  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];

  assign Data_Ready    = !w_full && !w_prbs_on;
  assign Serial_Out    = r_sr[0];
  assign Word_Boundary = (r_bit_cnt == '0);
  assign Underflow     = r_underflow;

`ifdef TX_PRBS_EN
  logic [6:0]        r_lfsr;
  logic [6:0]        w_lfsr_nxt;
  logic [WORD_W-1:0] w_prbs_word;

  assign w_prbs_on = Prbs_En;

  // Ten Fibonacci steps of x^7+x^6+1; the first generated bit lands in bit 0.
  always_comb begin
    w_lfsr_nxt  = r_lfsr;
    w_prbs_word = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_prbs_word[i] = w_lfsr_nxt[6] ^ w_lfsr_nxt[5];
      w_lfsr_nxt     = {w_lfsr_nxt[5:0], w_prbs_word[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 7'h7F;
    end else if (w_load && w_prbs_on) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end
`else
  assign w_prbs_on = 1'b0;
`endif

  // Word loaded into the shifter at the end of the current word.
  always_comb begin
    w_load_word = w_empty ? IDLE_WORD : w_head;
`ifdef TX_PRBS_EN
    if (w_prbs_on) begin
      w_load_word = w_prbs_word;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= Data_In;
    end
  end

  // Empty test at a load uses pre-edge pointers, so a same-edge push waits a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_bit_cnt   <= '0;
      r_sr        <= IDLE_WORD;
      r_last_data <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_load) begin
        r_bit_cnt   <= '0;
        r_sr        <= w_load_word;
        r_last_data <= w_pop;
        r_underflow <= r_last_data && w_empty && !w_prbs_on;
      end else begin
        r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
        r_sr        <= {1'b0, r_sr[WORD_W-1:1]};
        r_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pma_tx_serializer.sv
// Self-checking bench for pma_tx_serializer: directed scenarios plus randomized traffic
// compared against a word-queue reference model.
`timescale 1ns/1ps

module tb_pma_tx_serializer;

  localparam int unsigned DEPTH = 4;
  localparam logic [9:0]  IDLE  = 10'b0101010101;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic [9:0] Data_In    = '0;
  logic       Data_Valid = 1'b0;
  logic       Data_Ready;
  logic       Serial_Out;
  logic       Word_Boundary;
  logic       Underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of accepted words, word on the line and bit position in it.
  logic [9:0] m_q[$];
  logic [9:0] m_word = IDLE;
  int         m_pos  = 0;
  logic       m_last = 1'b0;
  logic       m_uf   = 1'b0;
  logic       m_acc  = 1'b0;

  logic [9:0] out_words[$];

  always #1 clk = ~clk;

  pma_tx_serializer #(
    .FIFO_DEPTH(DEPTH),
    .IDLE_WORD (IDLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Data_In      (Data_In),
    .Data_Valid   (Data_Valid),
    .Data_Ready   (Data_Ready),
    .Serial_Out   (Serial_Out),
    .Word_Boundary(Word_Boundary),
    .Underflow    (Underflow)
  );

  // Word monitor: gathers 10 line bits starting at each Word_Boundary.
  initial begin
    logic [9:0] mon_w;
    logic [3:0] mon_cnt;
    logic       mon_active;
    mon_w = '0; mon_cnt = '0; mon_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (Word_Boundary) begin
          mon_active = 1'b1; mon_cnt = '0; mon_w = '0;
        end
        if (mon_active) begin
          mon_w[mon_cnt] = Serial_Out;
          mon_cnt = mon_cnt + 4'd1;
          if (mon_cnt == 4'd10) begin
            out_words.push_back(mon_w);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_q.delete();
    m_word = IDLE;
    m_pos  = 0;
    m_last = 1'b0;
    m_uf   = 1'b0;
  endtask

  // One bit period: drive inputs, advance the model at the edge, return at the negedge.
  task automatic tick(input logic v, input logic [9:0] d);
    Data_Valid = v;
    Data_In    = d;
    m_acc      = v && (m_q.size() < DEPTH);
    @(posedge clk);
    m_uf = 1'b0;
    if (m_pos == 9) begin
      m_pos = 0;
      if (m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_last = 1'b1;
      end else begin
        m_word = IDLE;
        m_uf   = m_last;
        m_last = 1'b0;
      end
    end else begin
      m_pos++;
    end
    if (m_acc) m_q.push_back(d);
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  task automatic test_reset();
    #0.3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (Serial_Out !== IDLE[0]) begin
      failures++; $display("FAIL reset_serial_out got=%b exp=%b", Serial_Out, IDLE[0]);
    end
    checks++;
    if (Word_Boundary !== 1'b1) begin
      failures++; $display("FAIL reset_word_boundary got=%b exp=1", Word_Boundary);
    end
    checks++;
    if (Data_Ready !== 1'b1) begin
      failures++; $display("FAIL reset_data_ready got=%b exp=1", Data_Ready);
    end
    checks++;
    if (Underflow !== 1'b0) begin
      failures++; $display("FAIL reset_underflow got=%b exp=0", Underflow);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 30; k++) begin
      checks++;
      if ({Serial_Out, Word_Boundary, Underflow} !== {IDLE[k%10], (k % 10 == 0), 1'b0}) begin
        failures++;
        $display("FAIL idle_pattern cyc=%0d got(so,wb,uf)=%b%b%b exp=%b%b0", k,
                 Serial_Out, Word_Boundary, Underflow, IDLE[k%10], (k % 10 == 0));
      end
      tick(1'b0, '0);
    end
  endtask

  task automatic test_single_word();
    logic [9:0] w;
    int uf_cnt;
    w = 10'h3A5;
    for (int n = 0; n < 12 && m_pos != 2; n++) tick(1'b0, '0);
    tick(1'b1, w);
    for (int n = 0; n < 12 && m_pos != 0; n++) tick(1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (Serial_Out !== w[i] || Word_Boundary !== (i == 0)) begin
        failures++;
        $display("FAIL single_word_bit i=%0d got(so,wb)=%b%b exp=%b%b", i,
                 Serial_Out, Word_Boundary, w[i], (i == 0));
      end
      tick(1'b0, '0);
    end
    uf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (Serial_Out !== IDLE[i%10]) begin
        failures++; $display("FAIL single_idle_after i=%0d got=%b exp=%b", i, Serial_Out, IDLE[i%10]);
      end
      if (i == 0) begin
        checks++;
        if (Underflow !== 1'b1) begin
          failures++; $display("FAIL single_underflow_pulse got=%b exp=1", Underflow);
        end
      end
      if (Underflow === 1'b1) uf_cnt++;
      tick(1'b0, '0);
    end
    checks++;
    if (uf_cnt != 1) begin
      failures++; $display("FAIL single_underflow_count got=%0d exp=1", uf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] w[5];
    logic [9:0] exp_w;
    int k;
    bit dr_checked;
    for (int n = 0; n < 5; n++) w[n] = {3'(n + 5), 7'($urandom)};
    for (int n = 0; n < 12 && m_pos != 0; n++) tick(1'b0, '0);
    out_words.delete();
    k = 0;
    dr_checked = 1'b0;
    for (int n = 0; n < 40 && k < 5; n++) begin
      if (k == 4 && !dr_checked) begin
        dr_checked = 1'b1;
        checks++;
        if (Data_Ready !== 1'b0) begin
          failures++; $display("FAIL b2b_ready_after_4 got=%b exp=0", Data_Ready);
        end
      end
      checks++;
      if (Data_Ready !== (m_q.size() < DEPTH)) begin
        failures++; $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, Data_Ready, (m_q.size() < DEPTH));
      end
      tick(1'b1, w[k]);
      if (m_acc) k++;
    end
    checks++;
    if (k != 5) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp=5", k);
    end
    repeat (70) tick(1'b0, '0);
    checks++;
    if (out_words.size() < 7) begin
      failures++; $display("FAIL b2b_word_count got=%0d exp>=7", out_words.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        exp_w = (i >= 1 && i <= 5) ? w[i-1] : IDLE;
        checks++;
        if (out_words[i] !== exp_w) begin
          failures++; $display("FAIL b2b_word i=%0d got=%h exp=%h", i, out_words[i], exp_w);
        end
      end
    end
  endtask

  task automatic test_same_edge_push();
    logic [9:0] w;
    w = {3'b111, 7'($urandom)};
    for (int n = 0; n < 12 && m_pos != 9; n++) tick(1'b0, '0);
    checks++;
    if (Data_Ready !== 1'b1) begin
      failures++; $display("FAIL same_edge_ready got=%b exp=1", Data_Ready);
    end
    tick(1'b1, w);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (Serial_Out !== ((i < 10) ? IDLE[i%10] : w[i%10]) || Word_Boundary !== (i % 10 == 0)) begin
        failures++;
        $display("FAIL same_edge_bit i=%0d got(so,wb)=%b%b exp=%b%b", i, Serial_Out, Word_Boundary,
                 ((i < 10) ? IDLE[i%10] : w[i%10]), (i % 10 == 0));
      end
      tick(1'b0, '0);
    end
  endtask

  task automatic test_reset_midword();
    logic [9:0] a;
    logic [9:0] b;
    int bad;
    a = {3'b110, 7'($urandom)};
    b = {3'b100, 7'($urandom)};
    for (int n = 0; n < 12 && m_pos != 0; n++) tick(1'b0, '0);
    tick(1'b1, a);
    tick(1'b1, b);
    tick(1'b0, '0);
    tick(1'b0, '0);
    checks++;
    if (Word_Boundary !== 1'b0) begin
      failures++; $display("FAIL midword_pre_reset_wb got=%b exp=0", Word_Boundary);
    end
    rst_n = 1'b0;
    #0.2;
    checks++;
    if ({Serial_Out, Word_Boundary, Data_Ready, Underflow} !== {IDLE[0], 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midword_async_reset got(so,wb,dr,uf)=%b%b%b%b exp=%b110",
               Serial_Out, Word_Boundary, Data_Ready, Underflow, IDLE[0]);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_words.delete();
    for (int k = 0; k < 30; k++) begin
      checks++;
      if ({Serial_Out, Word_Boundary, Data_Ready, Underflow} !== {IDLE[k%10], (k % 10 == 0), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL midword_after_release cyc=%0d got(so,wb,dr,uf)=%b%b%b%b exp=%b%b10", k,
                 Serial_Out, Word_Boundary, Data_Ready, Underflow, IDLE[k%10], (k % 10 == 0));
      end
      tick(1'b0, '0);
    end
    bad = 0;
    foreach (out_words[i]) if (out_words[i] !== IDLE) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL midword_residue got=%0d non-idle words exp=0", bad);
    end
  endtask

  task automatic test_random();
    logic [3:0] got;
    logic [3:0] exp;
    int pct;
    int cyc;
    cyc = 0;
    for (int phase = 0; phase < 3; phase++) begin
      pct = (phase == 0) ? 15 : ((phase == 1) ? 95 : 55);
      for (int n = 0; n < 300; n++) begin
        got = {Serial_Out, Word_Boundary, Data_Ready, Underflow};
        exp = {m_word[m_pos], (m_pos == 0), (m_q.size() < DEPTH), m_uf};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL random cyc=%0d got(so,wb,dr,uf)=%b exp=%b", cyc, got, exp);
        end
        tick($urandom_range(0, 99) < pct, 10'($urandom));
        cyc++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_same_edge_push();
    test_reset_midword();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
